// File: rtl/calib_coef_gen_if.sv
// Signal bundle between calib_coef_gen and its surroundings:
// controller, ADC front end and calibration EEPROM.
interface calib_coef_gen_if;
    logic       start;
    logic       smpl_vld;
    logic [7:0] smpl;
    logic       ref_sel;
    logic       ee_req;
    logic [7:0] ee_addr;
    logic [7:0] ee_wdata;
    logic       ee_ack;
    logic [7:0] off_out;
    logic [7:0] gain_out;
    logic       busy;
    logic       done;
    logic       err;

    // slave is the calibration block; master is everything around it
    modport slave (
        input  start, smpl_vld, smpl, ee_ack,
        output ref_sel, ee_req, ee_addr, ee_wdata, off_out, gain_out, busy, done, err
    );
    modport master (
        output start, smpl_vld, smpl, ee_ack,
        input  ref_sel, ee_req, ee_addr, ee_wdata, off_out, gain_out, busy, done, err
    );
endinterface

// File: rtl/calib_coef_gen.sv
// Offset/gain calibration: averages zero and full-scale references, derives the
// coefficient pair, writes it to EEPROM (offset then gain) and publishes it.
module calib_coef_gen #(
    parameter int unsigned LOG_N     = 4,
    parameter int unsigned SETTLE    = 4,
    parameter logic [7:0]  FS_TARGET = 8'hF0,
    parameter logic [7:0]  OFF_ADDR  = 8'h00,
    parameter logic [7:0]  GAIN_ADDR = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    calib_coef_gen_if.slave bus
);
    localparam int unsigned N      = 1 << LOG_N;
    localparam int unsigned ACC_W  = 8 + LOG_N;
    localparam int unsigned DIV_W  = 15;
    localparam int unsigned PH_LEN = SETTLE + N;
    localparam int unsigned CNT_W  = ($clog2(PH_LEN) > 4) ? $clog2(PH_LEN) : 4;

    localparam logic [CNT_W-1:0] LAST_SMPL = CNT_W'(PH_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_W - 1);
    localparam logic [DIV_W-1:0] DIV_NUM   = {FS_TARGET, 7'b000_0000};

    typedef enum logic [2:0] {
        IDLE, ACC_Z, ACC_F, OFFS, DIV, WR_OFF, WR_GAIN, FIN
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       avg_z, avg_f;
    logic [7:0]       off, den, gain;
    logic [DIV_W-1:0] div_num, quo;
    logic [7:0]       rem;

    logic       ref_sel_q, ee_req_q, busy_q, done_q, err_q;
    logic [7:0] ee_addr_q, ee_wdata_q, off_out_q, gain_out_q;

    assign bus.ref_sel  = ref_sel_q;
    assign bus.ee_req   = ee_req_q;
    assign bus.ee_addr  = ee_addr_q;
    assign bus.ee_wdata = ee_wdata_q;
    assign bus.off_out  = off_out_q;
    assign bus.gain_out = gain_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    // Accumulation datapath
    logic [ACC_W-1:0] acc_sum;
    logic [7:0]       acc_avg;
    logic             phase_last;

    assign acc_sum    = acc + ACC_W'(bus.smpl);
    assign acc_avg    = acc_sum[ACC_W-1 -: 8];
    assign phase_last = bus.smpl_vld && (cnt == LAST_SMPL);

    // Offset and divisor; the divisor clamps rather than wraps when adding
    // the negative offset would cross below zero or above 127 in two's complement.
    logic [7:0] off_c, sum_c, den_c;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        off_c = (avg_z >= 8'h80) ? 8'h80 : 8'h00 - avg_z;
        sum_c = avg_f + off_c;
        den_c = sum_c;
        if (!avg_f[7] && !off_c[7] && sum_c[7]) begin
            den_c = 8'hFF;
        end else if (!avg_f[7] && off_c[7] && sum_c[7]) begin
            den_c = 8'h00;
        end
    end

    // One restoring-division step per cycle
    logic [8:0]       rem_sh;
    logic             q_bit;
    logic [7:0]       rem_nxt;
    logic [DIV_W-1:0] quo_nxt;
    logic             gain_sat;

    assign rem_sh   = {rem, div_num[DIV_W-1]};
    assign q_bit    = (rem_sh >= {1'b0, den});
    assign rem_nxt  = q_bit ? 8'(rem_sh - {1'b0, den}) : rem_sh[7:0];
    assign quo_nxt  = {quo[DIV_W-2:0], q_bit};
    assign gain_sat = (den == 8'h00) || (quo_nxt[DIV_W-1:8] != '0);

    logic ee_hs;
    assign ee_hs = ee_req_q && bus.ee_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = ACC_Z;
            ACC_Z:   if (phase_last) state_nxt = ACC_F;
            ACC_F:   if (phase_last) state_nxt = OFFS;
            OFFS:    state_nxt = DIV;
            DIV:     if (cnt == DIV_LAST) state_nxt = WR_OFF;
            WR_OFF:  if (ee_hs) state_nxt = WR_GAIN;
            WR_GAIN: if (ee_hs) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc        <= '0;
            avg_z      <= '0;
            avg_f      <= '0;
            off        <= '0;
            den        <= '0;
            gain       <= '0;
            div_num    <= '0;
            quo        <= '0;
            rem        <= '0;
            ref_sel_q  <= 1'b0;
            ee_req_q   <= 1'b0;
            ee_addr_q  <= '0;
            ee_wdata_q <= '0;
            off_out_q  <= '0;
            gain_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q    <= 1'b1;
                        ref_sel_q <= 1'b0;
                        err_q     <= 1'b0;
                        cnt       <= '0;
                        acc       <= '0;
                    end
                end
                ACC_Z, ACC_F: begin
                    if (bus.smpl_vld) begin
                        if (cnt == LAST_SMPL) begin
                            if (state == ACC_Z) begin
                                avg_z     <= acc_avg;
                                ref_sel_q <= 1'b1;
                            end else begin
                                avg_f <= acc_avg;
                            end
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            if (cnt >= SETTLE_C) acc <= acc_sum;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                OFFS: begin
                    off     <= off_c;
                    den     <= den_c;
                    div_num <= DIV_NUM;
                    quo     <= '0;
                    rem     <= '0;
                    cnt     <= '0;
                end
                DIV: begin
                    div_num <= {div_num[DIV_W-2:0], 1'b0};
                    rem     <= rem_nxt;
                    quo     <= quo_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == DIV_LAST) begin
                        gain       <= gain_sat ? 8'hFF : quo_nxt[7:0];
                        if (gain_sat) err_q <= 1'b1;
                        ee_req_q   <= 1'b1;
                        ee_addr_q  <= OFF_ADDR;
                        ee_wdata_q <= off;
                    end
                end
                WR_OFF: begin
                    if (ee_hs) ee_req_q <= 1'b0;
                end
                WR_GAIN: begin
                    // Request is low for exactly one cycle between the two writes
                    if (ee_hs) begin
                        ee_req_q   <= 1'b0;
                        off_out_q  <= off;
                        gain_out_q <= gain;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        ref_sel_q  <= 1'b0;
                    end else if (!ee_req_q) begin
                        ee_req_q   <= 1'b1;
                        ee_addr_q  <= GAIN_ADDR;
                        ee_wdata_q <= gain;
                    end
                end
                FIN: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calib_coef_gen.sv
// Scoreboard bench for calib_coef_gen: directed calibration runs with an ADC model,
// an EEPROM responder with programmable ack delay, and a decoupled output monitor.
module tb_calib_coef_gen;
    logic clk = 1'b0;
    logic rst;

    calib_coef_gen_if bus ();

    calib_coef_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0] off;
        logic [7:0] gain;
        logic       err;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [7:0] z_val, f_val;
    bit         junk, gaps;
    int         ack_dly;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.ref_sel, bus.ee_req, bus.ee_addr, bus.ee_wdata,
                    bus.off_out, bus.gain_out, bus.busy, bus.done, bus.err});
    endfunction

    // ADC model: the first four valid samples after each reference change can be junk
    initial begin : adc
        int   n;
        logic prev_ref;
        n = 0;
        prev_ref = 1'b0;
        bus.smpl_vld = 1'b0;
        bus.smpl     = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.ref_sel !== prev_ref) n = 0;
            prev_ref = bus.ref_sel;
            if (bus.busy === 1'b1) begin
                bus.smpl_vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.smpl     = (junk && n < 4) ? 8'hFF : (bus.ref_sel ? f_val : z_val);
                if (bus.smpl_vld) n++;
            end else begin
                bus.smpl_vld = 1'b0;
                bus.smpl     = 8'h00;
            end
        end
    end

    // EEPROM responder: acks after ack_dly cycles of held request
    initial begin : eeprom
        int w;
        w = 0;
        bus.ee_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.ee_ack = 1'b0;
            if (bus.ee_req === 1'b1) begin
                if (w >= ack_dly) begin
                    bus.ee_ack = 1'b1;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Monitor: compares writes and results against the scoreboard queues
    initial begin : monitor
        logic prev_done;
        res_t r;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                if (bus.ee_req === 1'b1) begin
                    if (wq.size() == 0) begin
                        check("write_queue_has_entry", 64'(wq.size()), 64'd1);
                    end else begin
                        check("ee_addr", 64'(bus.ee_addr), 64'(wq[0].addr));
                        check("ee_wdata", 64'(bus.ee_wdata), 64'(wq[0].data));
                        if (bus.ee_ack === 1'b1) void'(wq.pop_front());
                    end
                end
                if (bus.done === 1'b1) begin
                    done_cnt++;
                    check("done_pulse_width", 64'(prev_done), 64'd0);
                    if (rq.size() == 0) begin
                        check("result_queue_has_entry", 64'(rq.size()), 64'd1);
                    end else begin
                        r = rq.pop_front();
                        check("off_out", 64'(bus.off_out), 64'(r.off));
                        check("gain_out", 64'(bus.gain_out), 64'(r.gain));
                        check("err", 64'(bus.err), 64'(r.err));
                    end
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic run_cal(input logic [7:0] z, input logic [7:0] f, input bit jk, input bit gp,
                           input int ad, input bit lat_chk, input bit poke,
                           input logic [7:0] eo, input logic [7:0] eg, input logic ee);
        int n, lat, d0;
        z_val = z; f_val = f; junk = jk; gaps = gp; ack_dly = ad;
        wq.push_back(wr_t'{8'h00, eo});
        wq.push_back(wr_t'{8'h01, eg});
        rq.push_back(res_t'{eo, eg, ee});
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("err_cleared_on_start", 64'(bus.err), 64'd0);
        if (lat_chk) begin
            // 20 full-scale samples + 1 OFFS cycle + 15 DIV cycles before ee_req rises
            n = 0;
            while (bus.ref_sel !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            lat = 0;
            while (bus.ee_req !== 1'b1 && lat < 200) begin
                @(negedge clk);
                lat++;
                bus.start = poke && (lat == 5);
            end
            bus.start = 1'b0;
            check("offs_div_latency", 64'(lat), 64'd36);
        end
        n = 0;
        while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("idle_after_done", 64'({bus.busy, bus.done, bus.ee_req, bus.ref_sel}), 64'd0);
        check("writes_consumed", 64'(wq.size()), 64'd0);
    endtask

    task automatic rst_mid(input bit in_wr);
        int n;
        z_val = 8'hA0; f_val = 8'hFF; junk = 1'b0; gaps = 1'b0; ack_dly = 7;
        wq.push_back(wr_t'{8'h00, 8'h80});
        wq.push_back(wr_t'{8'h01, 8'hF1});
        rq.push_back(res_t'{8'h80, 8'hF1, 1'b0});
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        if (in_wr) begin
            while (bus.ee_req !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            check("req_before_rst", 64'(bus.ee_req), 64'd1);
        end else begin
            while (bus.ref_sel !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            repeat (28) @(negedge clk);
            check("busy_in_div", 64'({bus.busy, bus.ee_req}), 64'b10);
        end
        rst = 1'b1;
        @(negedge clk);
        check(in_wr ? "rst_in_wr_off" : "rst_in_div", outs(), 64'd0);
        rst = 1'b0;
        wq.delete();
        rq.delete();
        repeat (12) @(negedge clk);
        check("quiet_after_rst", outs(), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        z_val = 8'h00; f_val = 8'h00; junk = 1'b0; gaps = 1'b0; ack_dly = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs(), 64'd0);

        //       zero   fs     jk gp ack lat poke off    gain   err
        run_cal(8'h10, 8'hD0, 0, 0, 0,  1,  0,   8'hF0, 8'hA0, 1'b0);
        run_cal(8'hA0, 8'hFF, 0, 0, 0,  1,  0,   8'h80, 8'hF1, 1'b0);
        run_cal(8'h00, 8'h00, 0, 0, 0,  0,  0,   8'h00, 8'hFF, 1'b1);
        run_cal(8'h10, 8'hD0, 0, 0, 0,  1,  1,   8'hF0, 8'hA0, 1'b0);
        run_cal(8'h00, 8'h40, 0, 0, 0,  0,  0,   8'h00, 8'hFF, 1'b1);
        run_cal(8'h50, 8'h30, 0, 0, 0,  0,  0,   8'hB0, 8'hFF, 1'b1);
        run_cal(8'h10, 8'hD0, 1, 1, 1,  0,  0,   8'hF0, 8'hA0, 1'b0);
        run_cal(8'hA0, 8'hFF, 0, 1, 7,  0,  0,   8'h80, 8'hF1, 1'b0);

        rst_mid(1'b0);
        run_cal(8'h10, 8'hD0, 0, 0, 1,  1,  0,   8'hF0, 8'hA0, 1'b0);
        rst_mid(1'b1);
        run_cal(8'hA0, 8'hFF, 1, 1, 0,  0,  0,   8'h80, 8'hF1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
